// File: rtl/red_pitaya_iq_demodulator_block.sv
// rtl/red_pitaya_iq_demodulator_block.sv - IQ demodulator: sin/cos mixing, boxcar accumulate-and-dump, saturated I/Q
// Optional sticky overflow flags (clr_ovf_i / overflow_o) are built when IQ_DEMOD_OVERFLOW_EN is defined.
module red_pitaya_iq_demodulator_block #(
   parameter int INBITS  = 14,
   parameter int SINBITS = 14,
   parameter int OUTBITS = 18,
   parameter int AVGMAX  = 10
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic signed [INBITS-1:0]  signal_i,
   input  logic signed [SINBITS-1:0] sin,
   input  logic signed [SINBITS-1:0] cos,
   input  logic [3:0]                avg_log2_i,
`ifdef IQ_DEMOD_OVERFLOW_EN
   input  logic                      clr_ovf_i,
   output logic [1:0]                overflow_o,
`endif
   output logic signed [OUTBITS-1:0] signal1_o,
   output logic signed [OUTBITS-1:0] signal2_o,
   output logic                      valid_o
);

   // Full product width, and accumulator width that holds 2^AVGMAX products without overflow.
   localparam int PW     = INBITS + SINBITS;
   localparam int AW     = PW + AVGMAX;
   localparam int CW     = (AVGMAX > 0) ? AVGMAX : 1;
   // Base right shift at a single-sample window; the window exponent adds to it.
   localparam int SHBASE = PW - 1 - OUTBITS;
   localparam logic [3:0] NMAX = 4'(AVGMAX);
   localparam logic [CW:0] ONE = (CW+1)'(1);
   // Output range expressed at accumulator width for the saturation compare.
   localparam logic signed [AW-1:0] OUT_MAX = {{(AW-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
   localparam logic signed [AW-1:0] OUT_MIN = ~OUT_MAX;

   logic signed [PW-1:0]  p1_d, p2_d;
   logic signed [PW-1:0]  p1_q, p2_q;
   logic signed [AW-1:0]  p1_ext, p2_ext;
   logic signed [AW-1:0]  acc1_q, acc2_q;
   logic signed [AW-1:0]  sum1, sum2;
   logic signed [AW-1:0]  sh1, sh2;
   logic signed [OUTBITS-1:0] sat1, sat2;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         cnt_last;
   logic [3:0]            nl_q;
   logic [3:0]            avg_clamped;
   logic [3:0]            n_eff;
   logic [5:0]            shamt;
   logic                  win_start;
   logic                  dump;

   // Clip a shifted window sum to the signed output range.
   function automatic logic signed [OUTBITS-1:0] sat_out(input logic signed [AW-1:0] v);
      if (v > OUT_MAX)
         sat_out = OUT_MAX[OUTBITS-1:0];
      else if (v < OUT_MIN)
         sat_out = OUT_MIN[OUTBITS-1:0];
      else
         sat_out = v[OUTBITS-1:0];
   endfunction

   // Mixer: full-precision signed products of the input with both references.
   always_comb begin
      p1_d = $signed({{SINBITS{signal_i[INBITS-1]}}, signal_i}) * $signed({{INBITS{sin[SINBITS-1]}}, sin});
      p2_d = $signed({{SINBITS{signal_i[INBITS-1]}}, signal_i}) * $signed({{INBITS{cos[SINBITS-1]}}, cos});
   end

   // Window bookkeeping: the exponent is taken fresh from avg_log2_i at the first sample of a window,
   // then held from the latched copy so mid-window changes wait for the next window.
   always_comb begin
      avg_clamped = (avg_log2_i > NMAX) ? NMAX : avg_log2_i;
      win_start   = (cnt_q == '0);
      n_eff       = win_start ? avg_clamped : nl_q;
      cnt_last    = CW'((ONE << n_eff) - ONE);
      dump        = (cnt_q == cnt_last);
      shamt       = 6'(n_eff) + 6'(SHBASE);
   end

   // Accumulate-and-dump datapath: a window's first sample restarts the sum, which also covers a one-sample window.
   always_comb begin
      p1_ext = {{AVGMAX{p1_q[PW-1]}}, p1_q};
      p2_ext = {{AVGMAX{p2_q[PW-1]}}, p2_q};
      sum1   = win_start ? p1_ext : acc1_q + p1_ext;
      sum2   = win_start ? p2_ext : acc2_q + p2_ext;
      sh1    = sum1 >>> shamt;
      sh2    = sum2 >>> shamt;
      sat1   = sat_out(sh1);
      sat2   = sat_out(sh2);
   end

   // Stage 1: register the mixer products.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         p1_q <= '0;
         p2_q <= '0;
      end else begin
         p1_q <= p1_d;
         p2_q <= p2_d;
      end
   end

   // Window counter and latched exponent; counter wraps to zero on the dump cycle.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
         nl_q  <= '0;
      end else begin
         nl_q  <= n_eff;
         cnt_q <= dump ? '0 : cnt_q + CW'(1);
      end
   end

   // Stage 2 accumulators.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         acc1_q <= '0;
         acc2_q <= '0;
      end else begin
         acc1_q <= sum1;
         acc2_q <= sum2;
      end
   end

   // Output registers update only on a dump and hold otherwise; valid_o marks the update.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         signal1_o <= '0;
         signal2_o <= '0;
         valid_o   <= 1'b0;
      end else begin
         valid_o <= dump;
         if (dump) begin
            signal1_o <= sat1;
            signal2_o <= sat2;
         end
      end
   end

`ifdef IQ_DEMOD_OVERFLOW_EN
   logic [1:0] clip;

   // Per-channel clip detection at the saturator input.
   always_comb begin
      clip[0] = (sh1 > OUT_MAX) || (sh1 < OUT_MIN);
      clip[1] = (sh2 > OUT_MAX) || (sh2 < OUT_MIN);
   end

   // Sticky overflow flags: clear request is overridden by a clip in the same cycle.
   always_ff @(posedge clk_i) begin
      if (!rstn_i)
         overflow_o <= 2'b00;
      else
         overflow_o <= (overflow_o & {2{~clr_ovf_i}}) | (clip & {2{dump}});
   end
`endif

endmodule

// File: tb/tb_red_pitaya_iq_demodulator_block.sv
// tb/tb_red_pitaya_iq_demodulator_block.sv - self-checking bench for red_pitaya_iq_demodulator_block
module tb_red_pitaya_iq_demodulator_block;

   localparam int INB = 14;
   localparam int SB  = 14;
   localparam int OB  = 18;
   localparam int AM  = 10;
   localparam logic signed [63:0] MAXO = (64'sd1 <<< (OB-1)) - 64'sd1;
   localparam logic signed [63:0] MINO = -(64'sd1 <<< (OB-1));

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic signed [INB-1:0] sig = '0;
   logic signed [SB-1:0]  sn = '0;
   logic signed [SB-1:0]  cs = '0;
   logic [3:0]            avg = '0;
   logic signed [OB-1:0]  s1, s2;
   logic                  vld;

   int total = 0;
   int bad = 0;
   int nstrobe = 0;

   // Reference model state: the product waiting in the mixer register, the samples of the open window,
   // and the expected output registers.
   logic signed [63:0] mp1 = '0, mp2 = '0;
   logic signed [63:0] e1 = '0, e2 = '0;
   logic               ev = 1'b0;
   logic signed [63:0] w1[$];
   logic signed [63:0] w2[$];
   int                 wn = 0;

`ifdef IQ_DEMOD_OVERFLOW_EN
   logic       clr = 1'b0;
   logic [1:0] ovf;
   logic [1:0] eovf = 2'b00;
`endif

   always #5 clk = ~clk;

   red_pitaya_iq_demodulator_block #(
      .INBITS(INB), .SINBITS(SB), .OUTBITS(OB), .AVGMAX(AM)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .signal_i  (sig),
      .sin       (sn),
      .cos       (cs),
      .avg_log2_i(avg),
`ifdef IQ_DEMOD_OVERFLOW_EN
      .clr_ovf_i (clr),
      .overflow_o(ovf),
`endif
      .signal1_o (s1),
      .signal2_o (s2),
      .valid_o   (vld)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic rnd_inputs();
      sig = INB'($urandom);
      sn  = SB'($urandom);
      cs  = SB'($urandom);
   endtask

   // One clock edge of the reference: window of 2^N samples summed with plain arithmetic,
   // floor-shifted and clipped when the window fills.
   task automatic model_edge();
      logic signed [63:0] a1, a2, t1, t2;
      logic [1:0] cl;
      if (!rstn) begin
         w1.delete();
         w2.delete();
         mp1 = '0; mp2 = '0; e1 = '0; e2 = '0; ev = 1'b0;
`ifdef IQ_DEMOD_OVERFLOW_EN
         eovf = 2'b00;
`endif
         return;
      end
      if (w1.size() == 0) wn = (avg > 4'd10) ? 10 : int'(avg);
      w1.push_back(mp1);
      w2.push_back(mp2);
      ev = 1'b0;
      cl = 2'b00;
      if (w1.size() == (1 << wn)) begin
         a1 = '0;
         a2 = '0;
         foreach (w1[i]) begin
            a1 += w1[i];
            a2 += w2[i];
         end
         t1 = a1 >>> (wn + INB + SB - 1 - OB);
         t2 = a2 >>> (wn + INB + SB - 1 - OB);
         if (t1 > MAXO) begin e1 = MAXO; cl[0] = 1'b1; end
         else if (t1 < MINO) begin e1 = MINO; cl[0] = 1'b1; end
         else e1 = t1;
         if (t2 > MAXO) begin e2 = MAXO; cl[1] = 1'b1; end
         else if (t2 < MINO) begin e2 = MINO; cl[1] = 1'b1; end
         else e2 = t2;
         ev = 1'b1;
         w1.delete();
         w2.delete();
      end
`ifdef IQ_DEMOD_OVERFLOW_EN
      if (clr) eovf = 2'b00;
      eovf = eovf | cl;
`endif
      mp1 = 64'(sig) * 64'(sn);
      mp2 = 64'(sig) * 64'(cs);
   endtask

   // Advance one clock, update the model, then compare all outputs 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      if (vld === 1'b1) nstrobe++;
      chk("signal1", s1, e1);
      chk("signal2", s2, e2);
      chk("valid", vld, ev);
`ifdef IQ_DEMOD_OVERFLOW_EN
      chk("overflow", ovf, eovf);
`endif
   endtask

   initial begin
      // Reset held for 5 cycles with random inputs.
      rstn = 1'b0;
      repeat (5) begin
         rnd_inputs();
         cyc();
      end
      chk("rst_s1", s1, 0);
      chk("rst_s2", s2, 0);
      chk("rst_valid", vld, 0);

      // Single-sample window: full-scale product, strobe every cycle.
      rstn = 1'b1; avg = 4'd0; sig = 14'sd8191; sn = 14'sd8191; cs = 14'sd0;
      nstrobe = 0;
      repeat (4) cyc();
      chk("n0_s1", s1, 131040);
      chk("n0_s2", s2, 0);
      chk("n0_strobes", nstrobe, 4);

      // Four-sample window of constants.
      avg = 4'd2; sig = 14'sd1000; sn = -14'sd4096; cs = 14'sd4096;
      repeat (10) cyc();
      nstrobe = 0;
      repeat (8) cyc();
      chk("n2_strobes", nstrobe, 2);
      chk("n2_s1", s1, -8000);
      chk("n2_s2", s2, 8000);

      // Saturation of the (-full)x(-full) corner.
      avg = 4'd0; sig = -14'sd8192; sn = -14'sd8192; cs = -14'sd8192;
      repeat (6) cyc();
      chk("sat_s1", s1, 131071);
      chk("sat_s2", s2, 131071);
`ifdef IQ_DEMOD_OVERFLOW_EN
      chk("sat_ovf", ovf, 2'b11);
`endif
      sig = 14'sd0; sn = 14'sd0; cs = 14'sd0;
      repeat (3) cyc();
      chk("zero_s1", s1, 0);
`ifdef IQ_DEMOD_OVERFLOW_EN
      chk("ovf_sticky", ovf, 2'b11);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("ovf_cleared", ovf, 2'b00);
`endif

      // Mid-window change: N=3 window completes, then N=0.
      avg = 4'd3;
      nstrobe = 0;
      rnd_inputs(); cyc();
      rnd_inputs(); cyc();
      avg = 4'd0;
      repeat (6) begin
         rnd_inputs();
         cyc();
      end
      chk("mid_strobes", nstrobe, 1);
      chk("mid_last_valid", vld, 1);
      nstrobe = 0;
      repeat (4) begin
         rnd_inputs();
         cyc();
      end
      chk("mid_after_strobes", nstrobe, 4);

      // Requested exponent 15 clamps to a 1024-sample window.
      avg = 4'd15;
      nstrobe = 0;
      repeat (1023) begin
         rnd_inputs();
         cyc();
      end
      chk("n10_no_early_strobe", nstrobe, 0);
      rnd_inputs();
      cyc();
      chk("n10_strobe", nstrobe, 1);
      chk("n10_valid", vld, 1);

      // Reset at cnt=5 of an 8-sample window.
      avg = 4'd3;
      repeat (5) begin
         rnd_inputs();
         cyc();
      end
      rstn = 1'b0;
      rnd_inputs();
      cyc();
      chk("midrst_s1", s1, 0);
      rstn = 1'b1; sig = 14'sd1000; sn = -14'sd4096; cs = 14'sd4096;
      nstrobe = 0;
      repeat (7) cyc();
      chk("midrst_no_strobe", nstrobe, 0);
      cyc();
      chk("midrst_strobe", nstrobe, 1);
      chk("midrst_s1_val", s1, -7000);
      chk("midrst_s2_val", s2, 7000);

      // Random traffic with occasional window-length changes.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 15) == 0) avg = 4'($urandom_range(0, 5));
`ifdef IQ_DEMOD_OVERFLOW_EN
         clr = ($urandom_range(0, 7) == 0);
`endif
         rnd_inputs();
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
